// File: rtl/mem_pkt_arbiter_pkg.sv
// Shared types and constants for the two-port memory packet arbiter.
package mem_pkt_arbiter_pkg;

  localparam int MEM_BURST_LEN = 4;

  typedef logic unsigned [15:0] ulogic16;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } pktType_t;

  typedef enum logic unsigned [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } arbState_t;

  typedef struct packed {
    pktType_t                         Type;
    ulogic16                          Address;
    ulogic16 [0:MEM_BURST_LEN-1]      Data;
  } memPkt_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker. The last granted index is remembered so that
// on a tie the other requester wins; it only moves when the owner commits a grant.
module rr_arbiter2 (
  input  logic clk,
  input  logic resetN,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_update,
  output logic o_valid,
  output logic o_gntIdx
);

  logic r_lastGnt;

  // Pick a winner: a lone requester wins outright, a tie goes to the one not served last.
  always_comb begin
    o_valid  = i_req0 | i_req1;
    o_gntIdx = 1'b0;
    if (i_req0 && i_req1) begin
      o_gntIdx = ~r_lastGnt;
    end else if (i_req1) begin
      o_gntIdx = 1'b1;
    end
  end

  // Remember the committed winner; starting at 1 lets requester 0 take the first tie.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_lastGnt <= 1'b1;
    end else if (i_update && o_valid) begin
      r_lastGnt <= o_gntIdx;
    end
  end

endmodule

// File: rtl/mem_pkt_arbiter.sv
// Shares one memory controller between two packet requesters: grants one at a
// time, sends an address phase plus NUM_BEATS data beats, and returns read words.
module mem_pkt_arbiter
  import mem_pkt_arbiter_pkg::*;
#(
  parameter int NUM_BEATS = MEM_BURST_LEN
) (
  input  logic     clk,
  input  logic     resetN,
  input  logic     req0,
  input  logic     req1,
  input  memPkt_t  pkt0,
  input  memPkt_t  pkt1,
  output logic     gnt0,
  output logic     gnt1,
  output logic     done0,
  output logic     done1,
  output ulogic16  rdData [NUM_BEATS],
  output logic     mcAddrValid,
  output logic     mcRw,
  output ulogic16  mcDataOut,
  output logic     mcDataOE,
  input  ulogic16  mcDataIn
);

  localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  arbState_t        r_state;
  memPkt_t          r_pkt;
  logic             r_winner;
  logic [CNT_W-1:0] r_beat;
  ulogic16          r_rdBuf [NUM_BEATS];

  logic             w_anyReq;
  logic             w_pickIdx;
  logic             w_arbUpdate;
  memPkt_t          w_pickPkt;
  logic [CNT_W-1:0] w_nextBeat;

  // The round-robin pointer only advances when a grant is actually taken in IDLE.
  assign w_arbUpdate = (r_state == IDLE);
  assign w_pickPkt   = w_pickIdx ? pkt1 : pkt0;
  assign w_nextBeat  = r_beat + 1'b1;

  rr_arbiter2 u_rrArbiter (
    .clk      (clk),
    .resetN   (resetN),
    .i_req0   (req0),
    .i_req1   (req1),
    .i_update (w_arbUpdate),
    .o_valid  (w_anyReq),
    .o_gntIdx (w_pickIdx)
  );

  // Sequencer: all outputs are registered here so nothing passes combinationally from req/pkt.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= IDLE;
      r_pkt       <= '0;
      r_winner    <= 1'b0;
      r_beat      <= '0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      mcAddrValid <= 1'b0;
      mcRw        <= 1'b0;
      mcDataOut   <= '0;
      mcDataOE    <= 1'b0;
      for (int i = 0; i < NUM_BEATS; i++) begin
        r_rdBuf[i] <= '0;
        rdData[i]  <= '0;
      end
    end else begin
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      mcAddrValid <= 1'b0;
      mcRw        <= 1'b0;
      mcDataOut   <= '0;
      mcDataOE    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_state     <= ADDR;
            r_pkt       <= w_pickPkt;
            r_winner    <= w_pickIdx;
            gnt0        <= ~w_pickIdx;
            gnt1        <= w_pickIdx;
            mcAddrValid <= 1'b1;
            mcDataOE    <= 1'b1;
            mcDataOut   <= w_pickPkt.Address;
            mcRw        <= w_pickPkt.Type;
          end
        end
        ADDR: begin
          r_state <= DATA;
          r_beat  <= '0;
          if (r_pkt.Type == WRITE) begin
            mcDataOE  <= 1'b1;
            mcDataOut <= r_pkt.Data[0];
          end
        end
        DATA: begin
          r_rdBuf[r_beat] <= mcDataIn;
          if (r_beat == LAST_BEAT) begin
            r_state <= DONE;
            r_beat  <= '0;
            done0   <= ~r_winner;
            done1   <= r_winner;
            if (r_pkt.Type == READ) begin
              for (int i = 0; i < NUM_BEATS; i++) begin
                rdData[i] <= (i == NUM_BEATS - 1) ? mcDataIn : r_rdBuf[i];
              end
            end
          end else begin
            r_beat <= w_nextBeat;
            if (r_pkt.Type == WRITE) begin
              mcDataOE  <= 1'b1;
              mcDataOut <= r_pkt.Data[w_nextBeat];
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_pkt_arbiter.sv
// Directed bench for mem_pkt_arbiter with hand-computed expected values.
module tb_mem_pkt_arbiter;
  import mem_pkt_arbiter_pkg::*;

  logic    clk = 1'b0;
  logic    resetN;
  logic    req0, req1;
  memPkt_t pkt0, pkt1;
  logic    gnt0, gnt1, done0, done1;
  ulogic16 rdData [4];
  logic    mcAddrValid, mcRw, mcDataOE;
  ulogic16 mcDataOut, mcDataIn;

  int errorCount = 0;
  int checkCount = 0;

  mem_pkt_arbiter #(.NUM_BEATS(4)) dut (
    .clk         (clk),
    .resetN      (resetN),
    .req0        (req0),
    .req1        (req1),
    .pkt0        (pkt0),
    .pkt1        (pkt1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .done0       (done0),
    .done1       (done1),
    .rdData      (rdData),
    .mcAddrValid (mcAddrValid),
    .mcRw        (mcRw),
    .mcDataOut   (mcDataOut),
    .mcDataOE    (mcDataOE),
    .mcDataIn    (mcDataIn)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Builds a packet from its fields.
  function automatic memPkt_t makePkt(input pktType_t t, input ulogic16 a,
                                      input ulogic16 d0, input ulogic16 d1,
                                      input ulogic16 d2, input ulogic16 d3);
    memPkt_t p;
    p.Type    = t;
    p.Address = a;
    p.Data[0] = d0;
    p.Data[1] = d1;
    p.Data[2] = d2;
    p.Data[3] = d3;
    return p;
  endfunction

  // Holds reset for a couple of cycles and releases it on a falling edge.
  task automatic applyStimulus();
    resetN   = 1'b0;
    req0     = 1'b0;
    req1     = 1'b0;
    mcDataIn = '0;
    pkt0     = '0;
    pkt1     = '0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  // Safety net in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ulogic16 wrWords [4];
    ulogic16 rdWords [4];
    ulogic16 t5Words [4];
    logic    expIdx;
    wrWords = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    rdWords = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    t5Words = '{16'h5555, 16'h6666, 16'h7777, 16'h8888};

    // Reset state
    applyStimulus();
    checkOutput("reset gnt/done", {28'd0, gnt0, gnt1, done0, done1}, 32'd0);
    checkOutput("reset mc ctl", {29'd0, mcAddrValid, mcRw, mcDataOE}, 32'd0);
    checkOutput("reset mcDataOut", {16'd0, mcDataOut}, 32'd0);
    checkOutput("reset rdData0", {16'd0, rdData[0]}, 32'd0);

    // Test 1: WRITE from requester 0
    pkt0 = makePkt(WRITE, 16'h0040, wrWords[0], wrWords[1], wrWords[2], wrWords[3]);
    req0 = 1'b1;
    @(negedge clk);
    checkOutput("t1 gnt0/gnt1", {30'd0, gnt0, gnt1}, 32'd2);
    checkOutput("t1 addr ctl", {29'd0, mcAddrValid, mcRw, mcDataOE}, 32'b101);
    checkOutput("t1 addr", {16'd0, mcDataOut}, 32'h0040);
    req0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("t1 beat oe", {30'd0, mcAddrValid, mcDataOE}, 32'd1);
      checkOutput("t1 beat data", {16'd0, mcDataOut}, {16'd0, wrWords[k]});
    end
    @(negedge clk);
    checkOutput("t1 done0/done1", {30'd0, done0, done1}, 32'd2);
    checkOutput("t1 done oe", {31'd0, mcDataOE}, 32'd0);
    @(negedge clk);
    checkOutput("t1 idle done", {30'd0, done0, done1}, 32'd0);

    // Test 2: READ from requester 1
    pkt1 = makePkt(READ, 16'h0080, 16'h0, 16'h0, 16'h0, 16'h0);
    req1 = 1'b1;
    @(negedge clk);
    checkOutput("t2 gnt0/gnt1", {30'd0, gnt0, gnt1}, 32'd1);
    checkOutput("t2 addr ctl", {29'd0, mcAddrValid, mcRw, mcDataOE}, 32'b111);
    checkOutput("t2 addr", {16'd0, mcDataOut}, 32'h0080);
    req1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mcDataIn = rdWords[k];
      checkOutput("t2 beat oe", {31'd0, mcDataOE}, 32'd0);
      checkOutput("t2 beat out", {16'd0, mcDataOut}, 32'd0);
    end
    @(negedge clk);
    mcDataIn = '0;
    checkOutput("t2 done0/done1", {30'd0, done0, done1}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("t2 rdData", {16'd0, rdData[k]}, {16'd0, rdWords[k]});
    end
    @(negedge clk);

    // Tests 5 and 6: WRITE from requester 0 with req0 held past done
    pkt0 = makePkt(WRITE, 16'h00C0, t5Words[0], t5Words[1], t5Words[2], t5Words[3]);
    req0 = 1'b1;
    @(negedge clk);
    checkOutput("t5 gnt0", {31'd0, gnt0}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("t5 beat data", {16'd0, mcDataOut}, {16'd0, t5Words[k]});
    end
    @(negedge clk);
    checkOutput("t5 done0", {30'd0, done0, done1}, 32'd2);
    for (int k = 0; k < 4; k++) begin
      checkOutput("t5 rdData held", {16'd0, rdData[k]}, {16'd0, rdWords[k]});
    end
    @(negedge clk);
    checkOutput("t6 idle gap", {30'd0, gnt0, mcAddrValid}, 32'd0);
    @(negedge clk);
    checkOutput("t6 second gnt0", {30'd0, gnt0, mcAddrValid}, 32'd3);
    checkOutput("t6 second addr", {16'd0, mcDataOut}, 32'h00C0);
    req0 = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("t6 second done0", {30'd0, done0, done1}, 32'd2);
    @(negedge clk);

    // Test 4: reset asserted during beat 2 of a READ
    pkt1 = makePkt(READ, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0);
    req1 = 1'b1;
    @(negedge clk);
    checkOutput("t4 gnt1", {31'd0, gnt1}, 32'd1);
    req1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mcDataIn = 16'h9000 + 16'(k);
    end
    resetN = 1'b0;
    #1;
    checkOutput("t4 rst gnt/done", {28'd0, gnt0, gnt1, done0, done1}, 32'd0);
    checkOutput("t4 rst mc ctl", {29'd0, mcAddrValid, mcRw, mcDataOE}, 32'd0);
    checkOutput("t4 rst rdData0", {16'd0, rdData[0]}, 32'd0);
    checkOutput("t4 rst rdData3", {16'd0, rdData[3]}, 32'd0);
    @(negedge clk);
    resetN   = 1'b1;
    mcDataIn = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checkOutput("t4 stays idle", {29'd0, done0, done1, mcAddrValid}, 32'd0);
    end

    // Test 3: both requests held from reset, expect grants 0,1,0 seven cycles apart
    resetN = 1'b0;
    pkt0 = makePkt(WRITE, 16'h0200, 16'h1, 16'h2, 16'h3, 16'h4);
    pkt1 = makePkt(WRITE, 16'h0300, 16'h5, 16'h6, 16'h7, 16'h8);
    req0 = 1'b1;
    req1 = 1'b1;
    @(negedge clk);
    resetN = 1'b1;
    for (int p = 0; p < 3; p++) begin
      expIdx = (p == 1);
      @(negedge clk);
      checkOutput("t3 grant", {30'd0, gnt0, gnt1}, expIdx ? 32'd1 : 32'd2);
      checkOutput("t3 addr", {16'd0, mcDataOut}, expIdx ? 32'h0300 : 32'h0200);
      if (p == 2) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      repeat (5) @(negedge clk);
      @(negedge clk);
      checkOutput("t3 idle no gnt", {30'd0, gnt0, gnt1}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
